// File: rtl/qracc_bitserial_seq.sv
// Bit-serial MAC sequencer: steps each input bit through the macro's reset/drive/convert
// phases, then popcount-decodes the thermometer ADC codes and shift-accumulates per column.
module qracc_bitserial_seq #(
  parameter int NUM_ROWS       = 128,
  parameter int NUM_COLS       = 32,
  parameter int NUM_ADC_BITS   = 4,
  parameter int MAX_INPUT_BITS = 8,
  parameter int T_RST          = 2,
  parameter int T_DRV          = 2,
  parameter int T_CONV         = 1
) (
  input  logic                                                     clk,
  input  logic                                                     nrst,
  input  logic [7:0]                                               cfg_n_input_bits,
  input  logic                                                     cfg_binary,
  input  logic                                                     in_valid,
  output logic                                                     in_ready,
  input  logic [NUM_ROWS*MAX_INPUT_BITS-1:0]                       in_data,
  output logic [NUM_ROWS-1:0]                                      vrst_sel,
  output logic [NUM_ROWS-1:0]                                      vdr_sel,
  output logic [NUM_ROWS-1:0]                                      vss_sel,
  output logic                                                     adc_r2a,
  output logic                                                     adc_m2a,
  input  logic [(2**NUM_ADC_BITS-1)*NUM_COLS-1:0]                  adc_out,
  output logic                                                     out_valid,
  input  logic                                                     out_ready,
  output logic [NUM_COLS*(NUM_ADC_BITS+MAX_INPUT_BITS+2)-1:0]      out_data,
  output logic                                                     busy
);

  localparam int COMP  = 2**NUM_ADC_BITS - 1;
  localparam int ACC_W = NUM_ADC_BITS + MAX_INPUT_BITS + 2;
  localparam int CNT_W = $clog2(COMP + 1);
  localparam int NW    = $clog2(MAX_INPUT_BITS + 1);
  localparam int DW    = NUM_ROWS * MAX_INPUT_BITS;

  localparam logic [7:0] RST_LAST  = 8'(T_RST - 1);
  localparam logic [7:0] DRV_LAST  = 8'(T_DRV - 1);
  localparam logic [7:0] CONV_LAST = 8'(T_CONV - 1);
  localparam logic [7:0] MAX_N8    = 8'(MAX_INPUT_BITS);

  typedef enum logic [2:0] {IDLE, RST, DRV, CONV, ACC, DONE} state_e;

  state_e                    state_q, state_d;
  logic [7:0]                cnt_q, cnt_d;
  logic [NW-1:0]             bit_q, bit_d;
  logic [NW-1:0]             n_q, n_d;
  logic                      bin_q, bin_d;
  logic [DW-1:0]             data_q, data_d;
  logic [CNT_W-1:0]          count_q [NUM_COLS];
  logic [CNT_W-1:0]          count_d [NUM_COLS];
  logic signed [ACC_W-1:0]   acc_q [NUM_COLS];
  logic signed [ACC_W-1:0]   acc_d [NUM_COLS];

  logic [NUM_ROWS-1:0]       vrst_q, vrst_d, vdr_q, vdr_d, vss_q, vss_d;
  logic                      r2a_q, r2a_d, m2a_q, m2a_d;
  logic                      out_valid_q, out_valid_d, busy_q, busy_d, in_ready_q, in_ready_d;

  logic [NUM_ROWS-1:0]       drv_pat;
  logic                      last_bit;
  logic                      neg_term;
  logic signed [ACC_W-1:0]   val;
  logic signed [ACC_W-1:0]   term;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    n_d     = n_q;
    bin_d   = bin_q;
    data_d  = data_q;
    count_d = count_q;
    acc_d   = acc_q;
    val     = '0;
    term    = '0;

    for (int r = 0; r < NUM_ROWS; r++) begin
      drv_pat[r] = data_q[r*MAX_INPUT_BITS + int'(bit_q)];
    end
    last_bit = (bit_q == n_q - NW'(1));
    // The MSB of a multi-bit two's-complement input carries negative weight.
    neg_term = last_bit && (n_q > NW'(1));

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          bin_d   = cfg_binary;
          bit_d   = '0;
          cnt_d   = '0;
          if (cfg_n_input_bits == 8'd0)         n_d = NW'(1);
          else if (cfg_n_input_bits > MAX_N8)   n_d = NW'(MAX_INPUT_BITS);
          else                                  n_d = cfg_n_input_bits[NW-1:0];
          for (int c = 0; c < NUM_COLS; c++) acc_d[c] = '0;
          state_d = RST;
        end
      end
      RST: begin
        if (cnt_q == RST_LAST) begin
          cnt_d   = '0;
          state_d = DRV;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DRV: begin
        if (cnt_q == DRV_LAST) begin
          cnt_d   = '0;
          state_d = CONV;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      CONV: begin
        if (cnt_q == CONV_LAST) begin
          cnt_d = '0;
          // Popcount rather than priority decode so thermometer bubbles still count.
          for (int c = 0; c < NUM_COLS; c++) begin
            count_d[c] = '0;
            for (int b = 0; b < COMP; b++) begin
              count_d[c] = count_d[c] + CNT_W'(adc_out[c*COMP + b]);
            end
          end
          state_d = ACC;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ACC: begin
        for (int c = 0; c < NUM_COLS; c++) begin
          val = {{(ACC_W-CNT_W){1'b0}}, count_q[c]};
          if (bin_q) val = (val <<< 1) - ACC_W'(COMP);
          term = val <<< bit_q;
          acc_d[c] = neg_term ? (acc_q[c] - term) : (acc_q[c] + term);
        end
        if (last_bit) begin
          state_d = DONE;
        end else begin
          bit_d   = bit_q + NW'(1);
          state_d = RST;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they change on the same edge as the FSM.
    vrst_d      = (state_d == RST) ? '1 : '0;
    vdr_d       = (state_d == DRV || state_d == CONV) ? drv_pat : '0;
    vss_d       = (state_d == DRV || state_d == CONV) ? ~drv_pat : '0;
    r2a_d       = (state_d == RST);
    m2a_d       = (state_d == CONV);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
    in_ready_d  = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      n_q         <= NW'(1);
      bin_q       <= 1'b0;
      data_q      <= '0;
      for (int c = 0; c < NUM_COLS; c++) begin
        count_q[c] <= '0;
        acc_q[c]   <= '0;
      end
      vrst_q      <= '0;
      vdr_q       <= '0;
      vss_q       <= '0;
      r2a_q       <= 1'b0;
      m2a_q       <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      n_q         <= n_d;
      bin_q       <= bin_d;
      data_q      <= data_d;
      count_q     <= count_d;
      acc_q       <= acc_d;
      vrst_q      <= vrst_d;
      vdr_q       <= vdr_d;
      vss_q       <= vss_d;
      r2a_q       <= r2a_d;
      m2a_q       <= m2a_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign vrst_sel  = vrst_q;
  assign vdr_sel   = vdr_q;
  assign vss_sel   = vss_q;
  assign adc_r2a   = r2a_q;
  assign adc_m2a   = m2a_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign in_ready  = in_ready_q;

  for (genvar c = 0; c < NUM_COLS; c++) begin : g_out
    assign out_data[c*ACC_W +: ACC_W] = acc_q[c];
  end

endmodule

// File: tb/tb_qracc_bitserial_seq.sv
// Directed bench for qracc_bitserial_seq: latency, decoding, signed accumulation,
// row-select phasing, backpressure and mid-transaction reset.
module tb_qracc_bitserial_seq;

  localparam int ROWS  = 128;
  localparam int COLS  = 32;
  localparam int MIB   = 8;
  localparam int COMP  = 15;
  localparam int ACC_W = 14;

  logic                    clk;
  logic                    nrst;
  logic [7:0]              cfg_n_input_bits;
  logic                    cfg_binary;
  logic                    in_valid;
  logic                    in_ready;
  logic [ROWS*MIB-1:0]     in_data;
  logic [ROWS-1:0]         vrst_sel, vdr_sel, vss_sel;
  logic                    adc_r2a, adc_m2a;
  logic [COMP*COLS-1:0]    adc_out;
  logic                    out_valid;
  logic                    out_ready;
  logic [COLS*ACC_W-1:0]   out_data;
  logic                    busy;

  int tests_run    = 0;
  int tests_failed = 0;

  qracc_bitserial_seq dut (
    .clk              (clk),
    .nrst             (nrst),
    .cfg_n_input_bits (cfg_n_input_bits),
    .cfg_binary       (cfg_binary),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_data          (in_data),
    .vrst_sel         (vrst_sel),
    .vdr_sel          (vdr_sel),
    .vss_sel          (vss_sel),
    .adc_r2a          (adc_r2a),
    .adc_m2a          (adc_m2a),
    .adc_out          (adc_out),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_data         (out_data),
    .busy             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic signed [63:0] got,
                             input logic signed [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic signed [63:0] col_res(input int c);
    logic signed [ACC_W-1:0] v;
    v = out_data[c*ACC_W +: ACC_W];
    return v;
  endfunction

  function automatic logic [COMP*COLS-1:0] fill_adc(input logic [COMP-1:0] code);
    logic [COMP*COLS-1:0] a;
    for (int c = 0; c < COLS; c++) a[c*COMP +: COMP] = code;
    return a;
  endfunction

  function automatic logic [ROWS*MIB-1:0] make_rows(input int seed);
    logic [ROWS*MIB-1:0] d;
    for (int r = 0; r < ROWS; r++) d[r*MIB +: MIB] = 8'(r*seed + 5);
    return d;
  endfunction

  function automatic logic [ROWS-1:0] bit_pattern(input logic [ROWS*MIB-1:0] d, input int i);
    logic [ROWS-1:0] p;
    for (int r = 0; r < ROWS; r++) p[r] = d[r*MIB + i];
    return p;
  endfunction

  // Accept happens on the posedge; inputs are scrambled right after to show they are latched.
  task automatic applyStimulus(input logic [ROWS*MIB-1:0] data, input logic [7:0] nb,
                               input logic bin);
    @(negedge clk);
    in_data          = data;
    cfg_n_input_bits = nb;
    cfg_binary       = bin;
    in_valid         = 1'b1;
    @(posedge clk);
    #1;
    in_valid         = 1'b0;
    in_data          = ~data;
    cfg_n_input_bits = 8'd3;
    cfg_binary       = ~bin;
    checkOutput("busy_after_accept", busy, 1);
    checkOutput("in_ready_after_accept", in_ready, 0);
  endtask

  task automatic waitValid(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) checkOutput("valid_timeout", out_valid, 1);
  endtask

  task automatic popOutput();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("in_ready_after_pop", in_ready, 1);
    checkOutput("out_valid_after_pop", out_valid, 0);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    int i, ph;
    bit seen_valid;
    logic [ROWS*MIB-1:0] rows;
    logic [ROWS-1:0] pat;

    nrst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    cfg_n_input_bits = 8'd0; cfg_binary = 1'b0; adc_out = '0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_vrst", $countones(vrst_sel), 0);
    checkOutput("rst_r2a", adc_r2a, 0);
    checkOutput("rst_out_data0", col_res(0), 0);
    @(negedge clk);
    nrst = 1'b1;

    // Single-bit unsigned, plus a full-scale column.
    adc_out = fill_adc(15'h003F);
    adc_out[COMP +: COMP] = 15'h7FFF;
    applyStimulus(make_rows(3), 8'd1, 1'b0);
    waitValid(lat);
    checkOutput("t1_latency", lat, 6);
    checkOutput("t1_col0", col_res(0), 6);
    checkOutput("t1_col1", col_res(1), 15);
    popOutput();

    // Binary mode: 6 ones -> -3, zero code -> -15, full code -> +15.
    adc_out = fill_adc(15'h003F);
    adc_out[COMP +: COMP] = 15'h0000;
    applyStimulus(make_rows(3), 8'd1, 1'b1);
    waitValid(lat);
    checkOutput("t2_col0", col_res(0), -3);
    checkOutput("t2_col1", col_res(1), -15);
    popOutput();
    adc_out = fill_adc(15'h7FFF);
    applyStimulus(make_rows(3), 8'd1, 1'b1);
    waitValid(lat);
    checkOutput("t2_full", col_res(0), 15);
    popOutput();

    // Bubbled thermometer code decodes by popcount.
    adc_out = fill_adc(15'h5555);
    applyStimulus(make_rows(3), 8'd1, 1'b0);
    waitValid(lat);
    checkOutput("bubble_col0", col_res(0), 8);
    popOutput();

    // Multi-bit signed with phase-by-phase row-select checks.
    adc_out = fill_adc(15'h001F);
    rows = make_rows(37);
    applyStimulus(rows, 8'd4, 1'b0);
    for (int t = 1; t < 24; t++) begin
      @(posedge clk);
      #1;
      i   = t / 6;
      ph  = t % 6;
      pat = bit_pattern(rows, i);
      if (ph == 1) begin
        checkOutput("m_vrst_ones", $countones(vrst_sel), ROWS);
        checkOutput("m_r2a", adc_r2a, 1);
        checkOutput("m_rst_vdr", $countones(vdr_sel), 0);
      end else if (ph == 2 || ph == 3) begin
        checkOutput("m_drv_vdr", $countones(vdr_sel ^ pat), 0);
        checkOutput("m_drv_vss", $countones(vss_sel ^ ~pat), 0);
        checkOutput("m_drv_vrst", $countones(vrst_sel), 0);
      end else if (ph == 4) begin
        checkOutput("m_conv_m2a", adc_m2a, 1);
        checkOutput("m_conv_r2a", adc_r2a, 0);
        checkOutput("m_conv_vdr", $countones(vdr_sel ^ pat), 0);
      end else if (ph == 5) begin
        checkOutput("m_acc_sel", $countones(vdr_sel | vss_sel | vrst_sel), 0);
        checkOutput("m_acc_valid", out_valid, 0);
      end
    end
    @(posedge clk);
    #1;
    checkOutput("m_valid_at_24", out_valid, 1);
    checkOutput("m_col0", col_res(0), -5);
    checkOutput("m_col31", col_res(31), -5);

    // Backpressure: result holds while out_ready stays low.
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      checkOutput("bp_valid", out_valid, 1);
      checkOutput("bp_data", col_res(0), -5);
      checkOutput("bp_in_ready", in_ready, 0);
    end
    popOutput();

    // Precision clamp: 0 -> 1 bit, 12 -> 8 bits.
    applyStimulus(make_rows(11), 8'd0, 1'b0);
    waitValid(lat);
    checkOutput("clamp0_latency", lat, 6);
    checkOutput("clamp0_col0", col_res(0), 5);
    popOutput();
    applyStimulus(make_rows(11), 8'd12, 1'b0);
    waitValid(lat);
    checkOutput("clamp12_latency", lat, 48);
    checkOutput("clamp12_col0", col_res(0), -5);
    popOutput();

    // Asynchronous reset during DRV of bit 2.
    rows = make_rows(5);
    applyStimulus(rows, 8'd4, 1'b0);
    repeat (14) @(posedge clk);
    #1;
    checkOutput("mid_drv_vdr", $countones(vdr_sel ^ bit_pattern(rows, 2)), 0);
    checkOutput("mid_partial", col_res(0), 15);
    #2;
    nrst = 1'b0;
    #1;
    checkOutput("mid_vdr", $countones(vdr_sel | vss_sel | vrst_sel), 0);
    checkOutput("mid_busy", busy, 0);
    checkOutput("mid_in_ready", in_ready, 1);
    checkOutput("mid_out_valid", out_valid, 0);
    checkOutput("mid_m2a", adc_m2a, 0);
    checkOutput("mid_out_data", col_res(0), 0);
    @(negedge clk);
    nrst = 1'b1;
    seen_valid = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen_valid = 1'b1;
    end
    checkOutput("mid_no_valid", seen_valid, 0);

    adc_out = fill_adc(15'h003F);
    applyStimulus(make_rows(9), 8'd2, 1'b1);
    waitValid(lat);
    checkOutput("fresh_latency", lat, 12);
    checkOutput("fresh_col0", col_res(0), 3);
    popOutput();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
